// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared RC4 constants and type definitions.
// Used by the encrypt core, its swap sub-unit and the decrypt path.
//   KEY_BYTES : key length in bytes (k[i mod KEY_BYTES])
//   MSG_LEN   : message length in bytes
//   S_SIZE    : number of entries in the S permutation memory
//   rc4_state_t : top-level controller states
//   swap_step_t : sub-steps of one read/read/write/write swap
package rc4_pkg;

  localparam int unsigned KEY_BYTES = 3;
  localparam int unsigned MSG_LEN   = 32;
  localparam int unsigned S_SIZE    = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_PRGA,
    ST_DONE
  } rc4_state_t;

  // One S access per cycle; memory read data arrives two cycles after the address.
  typedef enum logic [2:0] {
    SW_RD_A,
    SW_WAIT_A,
    SW_CAP_A,
    SW_RD_B,
    SW_WAIT_B,
    SW_CAP_B,
    SW_WR_A,
    SW_WR_B
  } swap_step_t;

  // Plaintext byte is acceptable when it is a lowercase letter or a space.
  function automatic logic pt_char_ok(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
  endfunction

endpackage

// File: rtl/rc4_encrypt_core_if.sv
// rc4_encrypt_core_if -- control and memory-port bundle of rc4_encrypt_core.
//   start/key            : run request and 24-bit key (controller -> core)
//   finish/busy/pt_error : run status (core -> controller)
//   s_addr/s_wdata/s_wren/s_rdata : 256x8 S memory port (2-cycle read latency)
//   pt_addr/pt_rdata     : 32x8 plaintext read port (2-cycle read latency)
//   ct_addr/ct_wdata/ct_wren : 32x8 ciphertext write port
// Modports: slave = the core, master = controller/memories side.
interface rc4_encrypt_core_if;
  import rc4_pkg::*;

  localparam int unsigned MSG_AW = $clog2(MSG_LEN);

  logic                     start;
  logic [8*KEY_BYTES-1:0]   key;
  logic                     finish;
  logic                     busy;
  logic                     pt_error;
  logic [7:0]               s_addr;
  logic [7:0]               s_wdata;
  logic                     s_wren;
  logic [7:0]               s_rdata;
  logic [MSG_AW-1:0]        pt_addr;
  logic [7:0]               pt_rdata;
  logic [MSG_AW-1:0]        ct_addr;
  logic [7:0]               ct_wdata;
  logic                     ct_wren;

  modport slave (
    input  start, key, s_rdata, pt_rdata,
    output finish, busy, pt_error, s_addr, s_wdata, s_wren,
           pt_addr, ct_addr, ct_wdata, ct_wren
  );

  modport master (
    output start, key, s_rdata, pt_rdata,
    input  finish, busy, pt_error, s_addr, s_wdata, s_wren,
           pt_addr, ct_addr, ct_wdata, ct_wren
  );

endinterface

// File: rtl/rc4_swap_unit.sv
// rc4_swap_unit -- reads S[a], derives b = j_in + S[a] + j_add, reads S[b],
// then writes S[a] = old S[b] and S[b] = old S[a]. Shared by KSA and PRGA.
//   clk, rst_n      : clock, asynchronous active-low reset
//   go              : start a swap (accepted only while not active)
//   idx_a/j_in/j_add: first index, running j, extra addend (key byte or 0)
//   s_rdata         : S memory read data (2-cycle latency)
//   s_addr/s_wdata/s_wren : S memory port, all zero while idle
//   active          : a swap is in progress
//   done            : one-cycle pulse during the final write
//   j_out/sa/sb     : new j (= b), old S[a], old S[b]; held after done
module rc4_swap_unit
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] idx_a,
  input  logic [7:0] j_in,
  input  logic [7:0] j_add,
  input  logic [7:0] s_rdata,
  output logic [7:0] s_addr,
  output logic [7:0] s_wdata,
  output logic       s_wren,
  output logic       active,
  output logic       done,
  output logic [7:0] j_out,
  output logic [7:0] sa,
  output logic [7:0] sb
);

  swap_step_t step;
  logic [7:0] a_q;
  logic [7:0] j_q;
  logic [7:0] add_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      step   <= SW_RD_A;
      a_q    <= '0;
      j_q    <= '0;
      add_q  <= '0;
      j_out  <= '0;
      sa     <= '0;
      sb     <= '0;
    end else if (!active) begin
      if (go) begin
        active <= 1'b1;
        step   <= SW_RD_A;
        a_q    <= idx_a;
        j_q    <= j_in;
        add_q  <= j_add;
      end
    end else begin
      case (step)
        SW_CAP_A: begin
          sa    <= s_rdata;
          j_out <= j_q + s_rdata + add_q;
        end
        SW_CAP_B: sb <= s_rdata;
        default: ;
      endcase
      if (step == SW_WR_B) begin
        active <= 1'b0;
        step   <= SW_RD_A;
      end else begin
        step <= swap_step_t'(step + 3'd1);
      end
    end
  end

  // When a == b both writes hit one address; the second write restores old S[a].
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wren  = 1'b0;
    done    = 1'b0;
    if (active) begin
      case (step)
        SW_RD_A: s_addr = a_q;
        SW_RD_B: s_addr = j_out;
        SW_WR_A: begin
          s_addr  = a_q;
          s_wdata = sb;
          s_wren  = 1'b1;
        end
        SW_WR_B: begin
          s_addr  = j_out;
          s_wdata = sa;
          s_wren  = 1'b1;
          done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rc4_encrypt_core.sv
// rc4_encrypt_core -- RC4 encryption of a 32-byte message with a 3-byte key
// using external S, plaintext and ciphertext memories.
//   clk   : rising-edge system clock (CLOCK_50 domain)
//   rst_n : asynchronous active-low reset, aborts any run
//   bus   : rc4_encrypt_core_if.slave -- start/key in, finish/busy/pt_error out,
//           S memory port, plaintext read port, ciphertext write port
// Optional feature: define RC4_PLAINTEXT_CHECK_EN to flag (sticky pt_error)
// any plaintext byte that is not 'a'..'z' or space; otherwise pt_error is 0.
module rc4_encrypt_core
  import rc4_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  rc4_encrypt_core_if.slave bus
);

  rc4_state_t  state, nstate;
  logic [2:0]  step;
  logic [7:0]  i;
  logic [7:0]  j;
  logic [4:0]  k;
  logic [1:0]  kc;
  logic [23:0] key_q;

  logic        swap_go;
  logic [7:0]  swap_add;
  logic [7:0]  swap_addr, swap_wdata;
  logic        swap_wren, swap_active, swap_done;
  logic [7:0]  swap_j, swap_sa, swap_sb;
  logic        ct_write;

  rc4_swap_unit u_swap (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (swap_go),
    .idx_a   (i),
    .j_in    (j),
    .j_add   (swap_add),
    .s_rdata (bus.s_rdata),
    .s_addr  (swap_addr),
    .s_wdata (swap_wdata),
    .s_wren  (swap_wren),
    .active  (swap_active),
    .done    (swap_done),
    .j_out   (swap_j),
    .sa      (swap_sa),
    .sb      (swap_sb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (bus.start) nstate = ST_INIT;
      ST_INIT: if (i == 8'hFF) nstate = ST_KSA;
      ST_KSA:  if ((step != 3'd0) && swap_done && (i == 8'hFF)) nstate = ST_PRGA;
      ST_PRGA: if ((step == 3'd5) && (k == 5'd31)) nstate = ST_DONE;
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // KSA: step 0 launches the swap, step 1 waits for it.
  // PRGA: 0 advance i, 1 launch swap, 2 wait, 3 read S[sa+sb], 4 wait, 5 write ct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step  <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      kc    <= '0;
      key_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            key_q <= bus.key;
            step  <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            kc    <= '0;
          end
        end
        ST_INIT: i <= i + 8'd1;
        ST_KSA: begin
          if (step == 3'd0) begin
            step <= 3'd1;
          end else if (swap_done) begin
            step <= 3'd0;
            kc   <= (kc == 2'd2) ? 2'd0 : kc + 2'd1;
            if (i == 8'hFF) begin
              i <= '0;
              j <= '0;
            end else begin
              i <= i + 8'd1;
              j <= swap_j;
            end
          end
        end
        ST_PRGA: begin
          case (step)
            3'd0: begin
              i    <= i + 8'd1;
              step <= 3'd1;
            end
            3'd1: step <= 3'd2;
            3'd2: begin
              if (swap_done) begin
                j    <= swap_j;
                step <= 3'd3;
              end
            end
            3'd3: step <= 3'd4;
            3'd4: step <= 3'd5;
            default: begin
              step <= 3'd0;
              k    <= k + 5'd1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state == ST_INIT) || (state == ST_KSA) || (state == ST_PRGA);
    bus.finish   = (state == ST_DONE);
    swap_go      = ((state == ST_KSA) && (step == 3'd0)) ||
                   ((state == ST_PRGA) && (step == 3'd1));
    swap_add     = '0;
    if (state == ST_KSA) begin
      case (kc)
        2'd0:    swap_add = key_q[23:16];
        2'd1:    swap_add = key_q[15:8];
        default: swap_add = key_q[7:0];
      endcase
    end
    bus.s_addr   = '0;
    bus.s_wdata  = '0;
    bus.s_wren   = 1'b0;
    if (swap_active) begin
      bus.s_addr  = swap_addr;
      bus.s_wdata = swap_wdata;
      bus.s_wren  = swap_wren;
    end else if (state == ST_INIT) begin
      bus.s_addr  = i;
      bus.s_wdata = i;
      bus.s_wren  = 1'b1;
    end else if ((state == ST_PRGA) && (step == 3'd3)) begin
      bus.s_addr  = swap_sa + swap_sb;
    end
    ct_write     = (state == ST_PRGA) && (step == 3'd5);
    bus.pt_addr  = (state == ST_PRGA) ? k : '0;
    bus.ct_addr  = ct_write ? k : '0;
    bus.ct_wdata = ct_write ? (bus.s_rdata ^ bus.pt_rdata) : '0;
    bus.ct_wren  = ct_write;
  end

`ifdef RC4_PLAINTEXT_CHECK_EN
  logic pt_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_err_q <= 1'b0;
    end else if ((state == ST_IDLE) && bus.start) begin
      pt_err_q <= 1'b0;
    end else if (ct_write && !pt_char_ok(bus.pt_rdata)) begin
      pt_err_q <= 1'b1;
    end
  end

  assign bus.pt_error = pt_err_q;
`else
  assign bus.pt_error = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// tb_rc4_encrypt_core -- self-checking bench for rc4_encrypt_core.
// Provides S/plaintext/ciphertext memories with 2-cycle read latency and
// checks every ciphertext write against a plain RC4 reference model.
module tb_rc4_encrypt_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc4_encrypt_core_if bus();

  rc4_encrypt_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem [32];
  logic [7:0] ct_mem [32];
  logic [7:0] s_addr_q, s_q;
  logic [4:0] pt_addr_q;
  logic [7:0] pt_q;

  always @(posedge clk) begin
    s_addr_q  <= bus.s_addr;
    s_q       <= s_mem[s_addr_q];
    if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wdata;
    pt_addr_q <= bus.pt_addr;
    pt_q      <= pt_mem[pt_addr_q];
    if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wdata;
  end

  assign bus.s_rdata  = s_q;
  assign bus.pt_rdata = pt_q;

  int checks = 0;
  int errors = 0;
  int wr_idx = 0;
  int finish_cnt = 0;
  logic prev_finish = 1'b0;

  logic [7:0] exp_ct [32];
  logic       exp_perr;
  logic [7:0] model_in [32];
  logic [7:0] model_out [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Textbook RC4: model_out = model_in XOR keystream(kk).
  task automatic rc4_apply(input logic [23:0] kk);
    int unsigned s [256];
    int unsigned ii, jj, t;
    int unsigned kb [3];
    kb[0] = kk[23:16];
    kb[1] = kk[15:8];
    kb[2] = kk[7:0];
    for (int n = 0; n < 256; n++) s[n] = n;
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = (jj + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[jj]; s[jj] = t;
    end
    ii = 0;
    jj = 0;
    for (int m = 0; m < 32; m++) begin
      ii = (ii + 1) % 256;
      jj = (jj + s[ii]) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      model_out[m] = 8'(s[(s[ii] + s[jj]) % 256]) ^ model_in[m];
    end
  endtask

  task automatic compute_expected(input logic [23:0] kk);
    logic bad;
    bad = 1'b0;
    for (int m = 0; m < 32; m++) begin
      model_in[m] = pt_mem[m];
      if (!(((pt_mem[m] >= 8'h61) && (pt_mem[m] <= 8'h7A)) || (pt_mem[m] == 8'h20))) bad = 1'b1;
    end
    rc4_apply(kk);
    for (int m = 0; m < 32; m++) exp_ct[m] = model_out[m];
`ifdef RC4_PLAINTEXT_CHECK_EN
    exp_perr = bad;
`else
    exp_perr = 1'b0;
`endif
  endtask

  task automatic set_pt_string(input string s);
    for (int m = 0; m < 32; m++) pt_mem[m] = (m < s.len()) ? 8'(s[m]) : 8'h20;
  endtask

  task automatic set_pt_random();
    for (int m = 0; m < 32; m++)
      pt_mem[m] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h61 + $urandom_range(0, 25));
  endtask

  function automatic logic [63:0] outs();
    return {25'd0, bus.finish, bus.busy, bus.pt_error, bus.s_wren, bus.ct_wren,
            bus.s_addr, bus.s_wdata, bus.pt_addr, bus.ct_addr, bus.ct_wdata};
  endfunction

  // Compare process: every ciphertext write, every finish, and the idle gap after it.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("no_ct_wren_in_reset", bus.ct_wren, 0);
      wr_idx = 0;
      prev_finish = 1'b0;
    end else begin
      if (bus.ct_wren) begin
        if (wr_idx < 32) begin
          chk("ct_addr", bus.ct_addr, 64'(wr_idx));
          chk("ct_wdata", bus.ct_wdata, exp_ct[wr_idx]);
        end else begin
          chk("ct_write_count", 64'(wr_idx), 31);
        end
        wr_idx++;
      end
      if (prev_finish) chk("idle_after_finish", {bus.finish, bus.busy}, 0);
      if (bus.finish) begin
        chk("busy_at_finish", bus.busy, 0);
        chk("bytes_per_run", 64'(wr_idx), 32);
        chk("pt_error", bus.pt_error, exp_perr);
        wr_idx = 0;
        finish_cnt++;
      end
      prev_finish = bus.finish;
    end
  end

  task automatic wait_finish();
    int n;
    n = 0;
    while (!bus.finish && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("finish_timeout", bus.finish, 1);
  endtask

  task automatic start_run(input logic [23:0] kk);
    bus.key = kk;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic check_literal();
    logic [7:0] lit [9];
    lit = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int m = 0; m < 9; m++) chk("ct_literal", ct_mem[m], lit[m]);
  endtask

  initial begin
    int n, bad, base;
    logic [23:0] keys [3];
    bus.start = 1'b0;
    bus.key = '0;
    for (int m = 0; m < 32; m++) pt_mem[m] = 8'h00;
    #1;
    chk("reset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", outs(), 0);

    // Run 1: "Key" / "Plaintext", with S dump after INIT.
    set_pt_string("Plaintext");
    compute_expected(24'h4B6579);
    start_run(24'h4B6579);
    n = 0;
    for (int c = 0; c < 400 && n < 256; c++) begin
      if (bus.s_wren) n++;
      @(negedge clk);
    end
    chk("init_write_count", 64'(n), 256);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) bad++;
    chk("s_init_dump", 64'(bad), 0);
    wait_finish();
    check_literal();
`ifdef RC4_PLAINTEXT_CHECK_EN
    chk("pt_error_uppercase", bus.pt_error, 1);
`else
    chk("pt_error_tied", bus.pt_error, 0);
`endif
    repeat (2) @(negedge clk);

    // Run 2: round trip through decryption with the same key.
    set_pt_string("abcdefghijklmnopqrstuvwxyzabcdef");
    compute_expected(24'h000249);
    start_run(24'h000249);
    wait_finish();
    for (int m = 0; m < 32; m++) model_in[m] = ct_mem[m];
    rc4_apply(24'h000249);
    bad = 0;
    for (int m = 0; m < 32; m++) if (model_out[m] !== pt_mem[m]) bad++;
    chk("decrypt_roundtrip", 64'(bad), 0);
    chk("pt_error_lowercase", bus.pt_error, 0);
    repeat (2) @(negedge clk);

    // Run 3: reset during PRGA around byte 10, then a clean rerun.
    set_pt_string("Plaintext");
    compute_expected(24'h4B6579);
    start_run(24'h4B6579);
    n = 0;
    while (wr_idx < 10 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte10", 64'(wr_idx), 10);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    chk("held_reset_outputs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(24'h4B6579);
    wait_finish();
    check_literal();
    repeat (2) @(negedge clk);

    // Runs 4-6: start held high, random keys/plaintext, key scrambled mid-run.
    for (int r = 0; r < 3; r++) keys[r] = 24'($urandom);
    base = finish_cnt;
    set_pt_random();
    compute_expected(keys[0]);
    bus.key = keys[0];
    bus.start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(10, 2500)) @(negedge clk);
      bus.key = 24'($urandom);
      wait_finish();
      #1;
      if (r < 2) begin
        bus.key = keys[r + 1];
        set_pt_random();
        compute_expected(keys[r + 1]);
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
    chk("finish_pulses", 64'(finish_cnt - base), 3);
    chk("idle_after_runs", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
